// File: rtl/best_neighbor_select_pkg.sv
// Shared table layout and state encoding for the routing-table blocks.
// Used by fixSinkList and best_neighbor_select.
package best_neighbor_select_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int ADDR_WIDTH = 16;
    localparam int IDX_WIDTH  = 7;

    localparam logic [ADDR_WIDTH-1:0] NCOUNT_ADDR = 16'h068A;
    localparam logic [ADDR_WIDTH-1:0] SCOUNT_BASE = 16'h068E;
    localparam logic [ADDR_WIDTH-1:0] QVAL_BASE   = 16'h01C8;
    localparam logic [ADDR_WIDTH-1:0] RES_IDX_ADDR = 16'h06C0;
    localparam logic [ADDR_WIDTH-1:0] RES_Q_ADDR   = 16'h06C2;

    typedef enum logic [2:0] {
        WAIT_EN,
        WAIT_START,
        RD_NCOUNT,
        RD_SCOUNT,
        RD_QVAL,
        WR_IDX,
        WR_Q
    } state_t;

    // Word tables are laid out on 2-byte strides, wrapping at 16 bits.
    function automatic logic [ADDR_WIDTH-1:0] table_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [IDX_WIDTH-1:0]  idx
    );
        return base + {8'd0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/best_neighbor_select.sv
// Scans the neighbor tables and writes back the lowest-qValue neighbor
// that still has a route (nonzero sinkIDCount).
module best_neighbor_select #(
    parameter int WORD_WIDTH    = best_neighbor_select_pkg::WORD_WIDTH,
    parameter int MAX_NEIGHBORS = 64
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [15:0]           address,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  done
);
    import best_neighbor_select_pkg::*;

    localparam logic [WORD_WIDTH-1:0] MAX_W = WORD_WIDTH'(MAX_NEIGHBORS);
    localparam logic [IDX_WIDTH-1:0]  MAX_I = IDX_WIDTH'(MAX_NEIGHBORS);

    state_t                state;
    logic [IDX_WIDTH-1:0]  i;
    logic [IDX_WIDTH-1:0]  n;
    logic [WORD_WIDTH-1:0] best_index;
    logic [WORD_WIDTH-1:0] best_q;

    logic [IDX_WIDTH-1:0]  i_next;
    logic [IDX_WIDTH-1:0]  n_clamp;
    logic                  last;
    logic [WORD_WIDTH-1:0] idx_next;
    logic [WORD_WIDTH-1:0] q_next;

    assign i_next  = i + 1'b1;
    assign last    = (i_next == n);
    assign n_clamp = (data_in > MAX_W) ? MAX_I : data_in[IDX_WIDTH-1:0];

    // Strict compare so ties keep the earlier (lower) index.
    always_comb begin
        idx_next = best_index;
        q_next   = best_q;
        if (state == RD_QVAL && data_in < best_q) begin
            idx_next = WORD_WIDTH'(i);
            q_next   = data_in;
        end
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state      <= WAIT_EN;
            done       <= 1'b0;
            wr_en      <= 1'b0;
            address    <= NCOUNT_ADDR;
            data_out   <= '0;
            i          <= '0;
            n          <= '0;
            best_index <= '1;
            best_q     <= '1;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                WAIT_EN: begin
                    if (en) begin
                        done    <= 1'b0;
                        address <= NCOUNT_ADDR;
                        i       <= '0;
                        state   <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (start) begin
                        best_index <= '1;
                        best_q     <= '1;
                        state      <= RD_NCOUNT;
                    end
                end
                RD_NCOUNT: begin
                    n <= n_clamp;
                    if (n_clamp == '0) begin
                        address  <= RES_IDX_ADDR;
                        data_out <= idx_next;
                        wr_en    <= 1'b1;
                        state    <= WR_IDX;
                    end else begin
                        address <= SCOUNT_BASE;
                        state   <= RD_SCOUNT;
                    end
                end
                RD_SCOUNT, RD_QVAL: begin
                    if (state == RD_SCOUNT && data_in != '0) begin
                        address <= table_addr(QVAL_BASE, i);
                        state   <= RD_QVAL;
                    end else begin
                        best_index <= idx_next;
                        best_q     <= q_next;
                        i          <= i_next;
                        if (last) begin
                            address  <= RES_IDX_ADDR;
                            data_out <= idx_next;
                            wr_en    <= 1'b1;
                            state    <= WR_IDX;
                        end else begin
                            address <= table_addr(SCOUNT_BASE, i_next);
                            state   <= RD_SCOUNT;
                        end
                    end
                end
                WR_IDX: begin
                    address  <= RES_Q_ADDR;
                    data_out <= best_q;
                    wr_en    <= 1'b1;
                    state    <= WR_Q;
                end
                WR_Q: begin
                    done  <= 1'b1;
                    state <= WAIT_EN;
                end
                default: state <= WAIT_EN;
            endcase
        end
    end

endmodule

// File: tb/tb_best_neighbor_select.sv
// Bench for best_neighbor_select: word-memory model, write scoreboard,
// table-driven passes plus reset and clamp corner cases.
module tb_best_neighbor_select;

    logic        clock = 1'b0;
    logic        nrst  = 1'b0;
    logic        en    = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in;
    logic [15:0] address;
    logic        wr_en;
    logic [15:0] data_out;
    logic        done;

    logic [15:0] mem [4096];

    int checks = 0;
    int errors = 0;
    int qreads = 0;
    int wcount = 0;
    logic [15:0] qlast = 16'h0;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;
    wr_t sb[$];

    typedef struct packed {
        logic [7:0]       n;
        logic [3:0][15:0] sc;
        logic [3:0][15:0] qv;
        logic [15:0]      eidx;
        logic [15:0]      eq;
        logic [7:0]       elat;
        logic [7:0]       ereads;
        logic [15:0]      elast;
        logic             both;
    } vec_t;
    vec_t vecs[6];

    best_neighbor_select dut (
        .clock   (clock),
        .nrst    (nrst),
        .en      (en),
        .start   (start),
        .data_in (data_in),
        .address (address),
        .wr_en   (wr_en),
        .data_out(data_out),
        .done    (done)
    );

    always #5 clock = ~clock;

    assign data_in = mem[address[11:0]];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (nrst && address >= 16'h01C8 && address < 16'h0358) begin
            qreads++;
            qlast = address;
        end
        if (wr_en) begin
            wr_t e;
            wcount++;
            mem[address[11:0]] = data_out;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h:%h required=none",
                         address, data_out);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", {16'h0, address}, {16'h0, e.addr});
                chk("wr_data", {16'h0, data_out}, {16'h0, e.data});
            end
        end
    end

    task automatic clear_mem();
        for (int k = 0; k < 4096; k++) mem[k] = 16'h0;
    endtask

    task automatic load_vec(input vec_t v);
        clear_mem();
        mem[12'h68A] = {8'h0, v.n};
        for (int k = 0; k < 4; k++) begin
            mem[12'h68E + 2 * k] = v.sc[k];
            mem[12'h1C8 + 2 * k] = v.qv[k];
        end
    endtask

    task automatic run_pass(input string name, input logic [15:0] eidx,
                            input logic [15:0] eq, input int elat,
                            input int ereads, input logic [15:0] elast,
                            input logic both);
        int lat;
        sb.push_back('{addr: 16'h06C0, data: eidx});
        sb.push_back('{addr: 16'h06C2, data: eq});
        @(negedge clock);
        en = 1'b1;
        start = both;
        @(negedge clock);
        en = 1'b0;
        start = 1'b0;
        chk({name, "_armed_done"}, {31'h0, done}, 32'h0);
        if (both) repeat (2) @(negedge clock);
        qreads = 0;
        qlast = 16'h0;
        wcount = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        while (lat < 1000) begin
            @(posedge clock);
            #1;
            lat++;
            if (done) break;
        end
        chk({name, "_latency"}, lat, elat);
        chk({name, "_writes"}, wcount, 2);
        chk({name, "_sb_empty"}, sb.size(), 0);
        chk({name, "_qreads"}, qreads, ereads);
        chk({name, "_qlast"}, {16'h0, qlast}, {16'h0, elast});
        sb.delete();
    endtask

    initial begin
        vecs[0] = '{n: 8'd3, sc: {16'd0, 16'd4, 16'd1, 16'd2},
                    qv: {16'd0, 16'd7, 16'd5, 16'd9},
                    eidx: 16'd1, eq: 16'd5, elat: 8'd9, ereads: 8'd3,
                    elast: 16'h01CC, both: 1'b0};
        vecs[1] = '{n: 8'd3, sc: {16'd0, 16'd0, 16'd3, 16'd0},
                    qv: {16'd0, 16'd2, 16'd8, 16'd1},
                    eidx: 16'd1, eq: 16'd8, elat: 8'd7, ereads: 8'd1,
                    elast: 16'h01CA, both: 1'b0};
        vecs[2] = '{n: 8'd0, sc: {16'd1, 16'd1, 16'd1, 16'd1},
                    qv: {16'd1, 16'd1, 16'd1, 16'd1},
                    eidx: 16'hFFFF, eq: 16'hFFFF, elat: 8'd3, ereads: 8'd0,
                    elast: 16'h0, both: 1'b0};
        vecs[3] = '{n: 8'd2, sc: {16'd0, 16'd0, 16'd1, 16'd1},
                    qv: {16'd0, 16'd0, 16'd4, 16'd4},
                    eidx: 16'd0, eq: 16'd4, elat: 8'd7, ereads: 8'd2,
                    elast: 16'h01CA, both: 1'b1};
        vecs[4] = '{n: 8'd1, sc: {16'd0, 16'd0, 16'd0, 16'd5},
                    qv: {16'd0, 16'd0, 16'd0, 16'hFFFF},
                    eidx: 16'hFFFF, eq: 16'hFFFF, elat: 8'd5, ereads: 8'd1,
                    elast: 16'h01C8, both: 1'b0};
        vecs[5] = '{n: 8'd4, sc: {16'd1, 16'd1, 16'd1, 16'd1},
                    qv: {16'd12, 16'd3, 16'd3, 16'd10},
                    eidx: 16'd1, eq: 16'd3, elat: 8'd11, ereads: 8'd4,
                    elast: 16'h01CE, both: 1'b0};

        clear_mem();
        #12;
        chk("rst_address", {16'h0, address}, 32'h068A);
        chk("rst_wr_en", {31'h0, wr_en}, 32'h0);
        chk("rst_data_out", {16'h0, data_out}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        @(negedge clock);
        nrst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            load_vec(vecs[v]);
            run_pass($sformatf("vec%0d", v), vecs[v].eidx, vecs[v].eq,
                     int'(vecs[v].elat), int'(vecs[v].ereads),
                     vecs[v].elast, vecs[v].both);
        end

        // Asynchronous reset while the first qValue read is on the bus.
        load_vec(vecs[0]);
        @(negedge clock);
        en = 1'b1;
        @(negedge clock);
        en = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wcount = 0;
        for (int k = 0; k < 50; k++) begin
            if (address == 16'h01C8) break;
            @(negedge clock);
        end
        chk("abort_reached_qval", {16'h0, address}, 32'h01C8);
        #2;
        nrst = 1'b0;
        #1;
        chk("abort_address", {16'h0, address}, 32'h068A);
        chk("abort_wr_en", {31'h0, wr_en}, 32'h0);
        repeat (3) @(negedge clock);
        nrst = 1'b1;
        repeat (4) @(negedge clock);
        chk("abort_writes", wcount, 0);
        chk("abort_done", {31'h0, done}, 32'h0);
        run_pass("after_abort", 16'd1, 16'd5, 9, 3, 16'h01CC, 1'b0);

        // neighborCount beyond the clamp: only 64 neighbors are scanned.
        clear_mem();
        mem[12'h68A] = 16'd200;
        for (int k = 0; k < 200; k++) begin
            mem[12'h68E + 2 * k] = 16'd1;
            mem[12'h1C8 + 2 * k] = 16'(1000 - k);
        end
        run_pass("clamp", 16'd63, 16'd937, 131, 64, 16'h0246, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/best_neighbor_select.md
BEST_NEIGHBOR_SELECT -- requirements
Module: best_neighbor_select

Interface
REQ-001 The block SHALL have these ports, clock and reset first (name, direction, width, meaning):
- clock  in  1  single system clock, rising edge.
- nrst  in  1  reset, asynchronous and active-low.
- en  in  1  arms the block from WAIT_EN.
- start  in  1  begins one selection pass from WAIT_START.
- data_in  in  16  memory read data for the address driven this cycle.
- address  out  16  shared word-memory address, registered.
- wr_en  out  1  memory write strobe, registered, one cycle per write.
- data_out  out  16  memory write data, registered.
- done  out  1  pass complete; high from completion until next en.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- WORD_WIDTH, 16, datapath width.
- MAX_NEIGHBORS, 64, neighborCount clamp.

Function
REQ-003 The block SHALL read the tables that fixSinkList updates and select the neighbor with the lowest qValue among neighbors whose sinkIDCount is nonzero.
REQ-004 The memory addresses SHALL be:
- neighborCount 16'h68A.
- sinkIDCount[i] 16'h68E+2i.
- qValue[i] 16'h1C8+2i.
- result bestIndex 16'h6C0.
- result bestQ 16'h6C2.
REQ-005 The block SHALL sample data_in at the rising edge that ends the cycle in which the corresponding address was driven (zero-wait read).
REQ-006 The FSM states SHALL be WAIT_EN, WAIT_START, RD_NCOUNT, RD_SCOUNT, RD_QVAL, WR_IDX, WR_Q.
REQ-007 WAIT_EN: en=1 SHALL clear done, set address=16'h68A, clear i, and go to WAIT_START; start SHALL be ignored in this state.
REQ-008 WAIT_START: start=1 SHALL set bestIndex=16'hFFFF, bestQ=16'hFFFF, and go to RD_NCOUNT.
REQ-009 RD_NCOUNT SHALL latch n=min(data_in,MAX_NEIGHBORS); if n=0 it SHALL go to WR_IDX, otherwise to RD_SCOUNT with address=16'h68E.
REQ-010 RD_SCOUNT: if data_in=0 (no route), the block SHALL advance to the next neighbor without a qValue read; otherwise it SHALL go to RD_QVAL with address=16'h1C8+2i.
REQ-011 RD_QVAL: if data_in < bestQ (unsigned, strict), the block SHALL set bestQ=data_in and bestIndex=i; ties SHALL keep the lower index.
REQ-012 Advance SHALL mean i=i+1; if i=n, go to WR_IDX, else go to RD_SCOUNT with address=16'h68E+2i.
REQ-013 WR_IDX SHALL drive address=16'h6C0, data_out=bestIndex, wr_en=1 for exactly one cycle, then go to WR_Q.
REQ-014 WR_Q SHALL drive address=16'h6C2, data_out=bestQ, wr_en=1 for one cycle; at the next edge it SHALL set wr_en=0, done=1, and go to WAIT_EN.
REQ-015 Latency: with V valid and E empty neighbors, done SHALL rise 2V+E+3 edges after the edge that samples start.
REQ-016 If no neighbor is valid, both result words SHALL be written as 16'hFFFF.
REQ-017 en and start SHALL be ignored while a pass is in progress; start and en asserted together in WAIT_EN SHALL only arm the block.
REQ-018 Address arithmetic SHALL be 16-bit modulo; i SHALL be 7 bits.

Reset
REQ-019 nrst=0 SHALL immediately force: state=WAIT_EN, done=0, wr_en=0, address=16'h68A, data_out=0, i=0, bestIndex=16'hFFFF, bestQ=16'hFFFF.
REQ-020 Reset mid-pass SHALL abort the pass with no further writes, including during WR_IDX or WR_Q.

Structure
REQ-021 WORD_WIDTH, the five table/result addresses, and the state encoding SHALL live in the shared package used by fixSinkList.
REQ-022 The block SHALL be one flat module with no sub-module; the memory model belongs to the bench.

Verification
REQ-023 Scenario: neighborCount=3, sinkIDCount={2,1,4}, qValue={9,5,7} -> write 6C0=1, 6C2=5; done rises 9 edges after start.
REQ-024 Scenario: neighborCount=3, sinkIDCount={0,3,0}, qValue={1,8,2} -> write 6C0=1, 6C2=8; no reads of 1C8 or 1CC.
REQ-025 Scenario: neighborCount=0 -> write 6C0=FFFF, 6C2=FFFF; done rises 3 edges after start.
REQ-026 Scenario: tie, qValue={4,4}, both valid -> 6C0=0.
REQ-027 Scenario: nrst pulsed while in RD_QVAL -> wr_en stays 0, state returns to WAIT_EN; a following en plus start gives a correct full pass.
REQ-028 Scenario: neighborCount=200, all valid -> exactly 64 qValue reads; last qValue address read is 16'h246.
